pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline control and hazard unit for the 5-stage (F/D/E/M/W) datapath.
- Holds per-stage valid bits and destination/source register tags for the E, M and W stages.
- Detects RAW and load-use hazards and drives forwarding selects plus stall/flush enables to the datapath pipeline registers.
- Handles branches resolved in M, and counts stall and flush cycles for performance measurement.

Parameters:
RA_W, 5, register-address width (2^RA_W architectural registers; register 0 hardwired zero)
FWD_EN, 1, 1 = forwarding enabled; 0 = no forwarding, hazards resolved by stalling only
CNT_W, 16, width of the saturating performance counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-low
RsD  in  RA_W  source register A of the instruction in D
RtD  in  RA_W  source register B of the instruction in D
UsesRsD  in  1  instruction in D reads RsD
UsesRtD  in  1  instruction in D reads RtD
RegWriteD  in  1  instruction in D writes a register
MemToRegD  in  1  instruction in D is a load
WriteRegD  in  RA_W  destination register, resolved in D
PCSrcM  in  1  branch taken, resolved in M
StallF  out  1  hold the PC register
StallD  out  1  hold the D pipeline register
FlushD  out  1  clear the D pipeline register
FlushE  out  1  clear the E pipeline register (insert bubble)
ForwardAE  out  2  SrcA select: 00 register file, 10 ALUOutM, 01 ResultW
ForwardBE  out  2  SrcB select, same encoding as ForwardAE
RegWriteW  out  1  register-file write enable (valid-qualified)
WriteRegW  out  RA_W  register-file write address
ValidE, ValidM, ValidW  out  1 each  stage holds a real instruction
StallCount  out  CNT_W  cycles lost to hazard stalls
FlushCount  out  CNT_W  taken-branch flush events

Behaviour:
- Reset (reset=0) is asynchronous. It clears vD, all E/M/W state and both counters.
- Outputs during and immediately after reset: all 1-bit outputs 0, ForwardAE/BE = 00, WriteRegW = 0, counters 0.
- State per stage:
  - vD.
  - E: v, RegWrite, MemToReg, WriteReg, Rs, Rt.
  - M and W: v, RegWrite, MemToReg, WriteReg.
- Stage advance on every rising clk edge: E<-D, M<-E, W<-M. A source value is treated as a hazard source only when its valid bit is 1.
- Tag match definition: match(X, r) = vX & RegWriteX & (WriteRegX != 0) & (WriteRegX == r). Register 0 never causes a stall or a forward.
- Hazard term hz for the instruction in D: vD & ((UsesRsD & match on RsD) | (UsesRtD & match on RtD)).
  - FWD_EN=1: match against E only, with E also required to have MemToRegE=1 (load-use).
  - FWD_EN=0: match against E, M or W (any producer).
- Control outputs, combinational:
  - If PCSrcM=1: StallF=StallD=0, FlushD=FlushE=1. Branch takes priority over stall.
  - Else if hz: StallF=StallD=FlushE=1, FlushD=0.
  - Otherwise all four are 0.
- Next-state updates:
  - vD_next = FlushD ? 0 : (StallD ? vD : 1).
  - FlushE forces next vE=0.
  - PCSrcM forces next vM=0, squashing the wrong-path instruction currently in E.
- Forwarding (FWD_EN=1), evaluated on RsE for ForwardAE and on RtE for ForwardBE:
  - 10 if match(M).
  - else 01 if match(W).
  - else 00.
  - M has priority over W.
- With FWD_EN=0, ForwardAE/BE are constant 00.
- Write-back outputs: RegWriteW = vW & RegWriteW_tag. WriteRegW is the W tag.
- Latency: hazard and forward outputs are combinational from current state and D inputs. No added cycle.
- Counters:
  - StallCount increments on cycles with hz & !PCSrcM.
  - FlushCount increments on cycles with PCSrcM.
  - Both saturate at 2^CNT_W-1 (no wrap).
- Reset asserted mid-stall or mid-flush kills all in-flight tags. The first cycle after release has no stall.

Test Plan:
- Forwarding from M: add r3 then add r5,r3,r1 back-to-back (FWD_EN=1). With the second add in E: ForwardAE=10, StallF=0, StallCount=0.
- Load-use: lw r2 then add r4,r2,r2.
  - Exactly one cycle StallF=StallD=FlushE=1.
  - Next cycle ValidE=0.
  - When add reaches E: ForwardAE=ForwardBE=01.
  - StallCount=1.
- Register zero: producer writes r0, consumer reads r0, including via a load. No stall; ForwardAE/BE=00 throughout.
- Branch over stall: PCSrcM=1 in the same cycle as a load-use hazard.
  - StallF=0, FlushD=FlushE=1, StallCount unchanged, FlushCount=1.
  - Next cycle ValidE=0, ValidM=0.
- FWD_EN=0: add r3 then dependent add on r3. Three consecutive stall cycles, Forward=00 always, StallCount=3.
- Asynchronous reset: assert reset=0 between clk edges during a stall. All outputs go to 0 immediately. After release, a non-dependent stream sees no stalls and ValidW rises on the 4th edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline valid/tag tracking, hazard stall/flush, forwarding and perf counters
module pipe_hazard_ctrl #(
    parameter int RA_W   = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RA_W-1:0]  RsD,
    input  logic [RA_W-1:0]  RtD,
    input  logic             UsesRsD,
    input  logic             UsesRtD,
    input  logic             RegWriteD,
    input  logic             MemToRegD,
    input  logic [RA_W-1:0]  WriteRegD,
    input  logic             PCSrcM,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             RegWriteW,
    output logic [RA_W-1:0]  WriteRegW,
    output logic             ValidE,
    output logic             ValidM,
    output logic             ValidW,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);
    logic            v_d, v_e, v_m, v_w;
    logic            rw_e, rw_m, rw_w, mr_e;
    logic [RA_W-1:0] wr_e, wr_m, wr_w, rs_e, rt_e;
    logic            hz, hz_e, hz_m, hz_w;

    function automatic logic match(input logic v, input logic rw, input logic [RA_W-1:0] wr,
                                   input logic [RA_W-1:0] r);
        return v & rw & (wr != '0) & (wr == r);
    endfunction

    // hazard detection for the instruction in D; a taken branch overrides any stall
    always_comb begin
        hz_e   = (UsesRsD & match(v_e, rw_e, wr_e, RsD)) | (UsesRtD & match(v_e, rw_e, wr_e, RtD));
        hz_m   = (UsesRsD & match(v_m, rw_m, wr_m, RsD)) | (UsesRtD & match(v_m, rw_m, wr_m, RtD));
        hz_w   = (UsesRsD & match(v_w, rw_w, wr_w, RsD)) | (UsesRtD & match(v_w, rw_w, wr_w, RtD));
        hz     = v_d & ((FWD_EN != 0) ? (hz_e & mr_e) : (hz_e | hz_m | hz_w));
        StallF = hz & ~PCSrcM;
        StallD = hz & ~PCSrcM;
        FlushD = PCSrcM;
        FlushE = PCSrcM | hz;
    end

    // forwarding selects for the E operands, youngest producer (M) first
    always_comb begin
        ForwardAE = (FWD_EN == 0) ? 2'b00 : match(v_m, rw_m, wr_m, rs_e) ? 2'b10 :
                    match(v_w, rw_w, wr_w, rs_e) ? 2'b01 : 2'b00;
        ForwardBE = (FWD_EN == 0) ? 2'b00 : match(v_m, rw_m, wr_m, rt_e) ? 2'b10 :
                    match(v_w, rw_w, wr_w, rt_e) ? 2'b01 : 2'b00;
    end

    assign RegWriteW = v_w & rw_w;
    assign WriteRegW = wr_w;
    assign ValidE    = v_e;
    assign ValidM    = v_m;
    assign ValidW    = v_w;

    // stage advance; tags always move, only the valid bits are squashed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_d  <= 1'b0;
            v_e  <= 1'b0;
            rw_e <= 1'b0;
            mr_e <= 1'b0;
            wr_e <= '0;
            rs_e <= '0;
            rt_e <= '0;
            v_m  <= 1'b0;
            rw_m <= 1'b0;
            wr_m <= '0;
            v_w  <= 1'b0;
            rw_w <= 1'b0;
            wr_w <= '0;
        end else begin
            v_d  <= FlushD ? 1'b0 : (StallD ? v_d : 1'b1);
            v_e  <= v_d & ~FlushE;
            rw_e <= RegWriteD;
            mr_e <= MemToRegD;
            wr_e <= WriteRegD;
            rs_e <= RsD;
            rt_e <= RtD;
            v_m  <= v_e & ~PCSrcM;
            rw_m <= rw_e;
            wr_m <= wr_e;
            v_w  <= v_m;
            rw_w <= rw_m;
            wr_w <= wr_m;
        end
    end

    // saturating stall and flush counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (StallF && StallCount != '1) StallCount <= StallCount + 1'b1;
            if (PCSrcM && FlushCount != '1) FlushCount <= FlushCount + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors, corner sequences and randomized model check
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] rs_d = '0, rt_d = '0, wr_d = '0;
    logic       ur = 1'b0, ut = 1'b0, rw_d = 1'b0, mr_d = 1'b0, br = 1'b0;

    typedef struct packed {
        logic sf, sd, fd, fe;
        logic [1:0] fa, fb;
        logic rww;
        logic [4:0] wrw;
        logic ve, vm, vw;
        logic [15:0] sc, fc;
    } obs_t;

    typedef struct packed {
        logic v, rw, mr;
        logic [4:0] wr, rs, rt;
    } stg_t;

    typedef struct {
        logic [4:0] rs, rt;
        logic ur, ut, rw, mr;
        logic [4:0] wr;
        logic br, st, fd, fe;
        logic [1:0] fa, fb;
        logic rww;
        logic [4:0] wrw;
        logic ve, vm, vw;
        int sc, fc;
    } vec_t;

    logic       sf[2], sd[2], fd[2], fe[2], rww[2], ve[2], vm[2], vw[2];
    logic [1:0] fa[2], fb[2];
    logic [4:0] wrw[2];
    logic [15:0] sc[2], fc[2];
    obs_t o[2];

    int errs = 0;
    int checks = 0;

    stg_t ms[2][3];
    logic mvd[2];
    int   msc[2], mfc[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pipe_hazard_ctrl #(.RA_W(5), .FWD_EN(g), .CNT_W(16)) dut (
            .clk(clk), .reset(reset), .RsD(rs_d), .RtD(rt_d), .UsesRsD(ur), .UsesRtD(ut),
            .RegWriteD(rw_d), .MemToRegD(mr_d), .WriteRegD(wr_d), .PCSrcM(br),
            .StallF(sf[g]), .StallD(sd[g]), .FlushD(fd[g]), .FlushE(fe[g]),
            .ForwardAE(fa[g]), .ForwardBE(fb[g]), .RegWriteW(rww[g]), .WriteRegW(wrw[g]),
            .ValidE(ve[g]), .ValidM(vm[g]), .ValidW(vw[g]), .StallCount(sc[g]), .FlushCount(fc[g])
        );
        assign o[g] = {sf[g], sd[g], fd[g], fe[g], fa[g], fb[g], rww[g], wrw[g],
                       ve[g], vm[g], vw[g], sc[g], fc[g]};
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, rt, input logic u1, u2, w, m,
                         input logic [4:0] wr, input logic b);
        @(negedge clk);
        rs_d = rs; rt_d = rt; ur = u1; ut = u2; rw_d = w; mr_d = m; wr_d = wr; br = b;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        rs_d = '0; rt_d = '0; ur = 1'b0; ut = 1'b0; rw_d = 1'b0; mr_d = 1'b0; wr_d = '0; br = 1'b0;
        #1;
        chk("reset_held", {o[1], o[0]}, '0);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    function automatic vec_t mk(input logic [4:0] rs, rt, input logic u1, u2, w, m, input logic [4:0] wr,
                                input logic b, st, f_d, f_e, input logic [1:0] a, bb,
                                input logic rwe, input logic [4:0] wre, input logic e, mm, ww,
                                input int s, f);
        vec_t t;
        t = '{rs, rt, u1, u2, w, m, wr, b, st, f_d, f_e, a, bb, rwe, wre, e, mm, ww, s, f};
        return t;
    endfunction

    // reference model: stage array indexed 0=E, 1=M, 2=W
    function automatic logic mt(input stg_t s, input logic [4:0] r);
        return s.v && s.rw && s.wr != 0 && s.wr == r;
    endfunction

    function automatic logic mhz(input int f);
        logic h;
        h = 1'b0;
        for (int k = 0; k < 3; k++)
            if (f == 0 || (k == 0 && ms[f][k].mr))
                h |= (ur && mt(ms[f][k], rs_d)) || (ut && mt(ms[f][k], rt_d));
        return h && mvd[f];
    endfunction

    function automatic logic [1:0] mfw(input int f, input logic [4:0] r);
        if (f == 0) return 2'b00;
        if (mt(ms[f][1], r)) return 2'b10;
        if (mt(ms[f][2], r)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic obs_t mexp(input int f);
        logic h, s;
        h = mhz(f);
        s = h && !br;
        return {s, s, br, br | h, mfw(f, ms[f][0].rs), mfw(f, ms[f][0].rt),
                ms[f][2].v & ms[f][2].rw, ms[f][2].wr, ms[f][0].v, ms[f][1].v, ms[f][2].v,
                16'(msc[f]), 16'(mfc[f])};
    endfunction

    task automatic mstep(input int f);
        logic h;
        h = mhz(f);
        ms[f][2] = ms[f][1];
        ms[f][1] = ms[f][0];
        ms[f][1].v = ms[f][0].v && !br;
        ms[f][0] = '{mvd[f] && !br && !h, rw_d, mr_d, wr_d, rs_d, rt_d};
        if (h && !br && msc[f] < 65535) msc[f]++;
        if (br && mfc[f] < 65535) mfc[f]++;
        mvd[f] = !br && (h ? mvd[f] : 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout errs=%0d checks=%0d", errs, checks);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tv[13];
        obs_t e;
        logic [3:0] exp_st;
        tv[0]  = mk(0,0,0,0,0,0,0, 0, 0,0,0, 0,0, 0,0, 0,0,0, 0,0);
        tv[1]  = mk(1,2,1,1,1,0,3, 0, 0,0,0, 0,0, 0,0, 0,0,0, 0,0);
        tv[2]  = mk(3,1,1,1,1,0,5, 0, 0,0,0, 0,0, 0,0, 1,0,0, 0,0);
        tv[3]  = mk(1,0,1,0,1,1,2, 0, 0,0,0, 2,0, 0,0, 1,1,0, 0,0);
        tv[4]  = mk(2,2,1,1,1,0,4, 0, 1,0,1, 0,0, 1,3, 1,1,1, 0,0);
        tv[5]  = mk(2,2,1,1,1,0,4, 0, 0,0,0, 2,2, 1,5, 0,1,1, 1,0);
        tv[6]  = mk(1,1,1,1,1,0,0, 0, 0,0,0, 1,1, 1,2, 1,0,1, 1,0);
        tv[7]  = mk(0,0,1,0,1,1,0, 0, 0,0,0, 0,0, 0,4, 1,1,0, 1,0);
        tv[8]  = mk(0,0,1,1,1,0,9, 0, 0,0,0, 0,0, 1,4, 1,1,1, 1,0);
        tv[9]  = mk(1,0,1,0,1,1,7, 0, 0,0,0, 0,0, 1,0, 1,1,1, 1,0);
        tv[10] = mk(7,0,1,1,1,0,8, 1, 0,1,1, 0,0, 1,0, 1,1,1, 1,0);
        tv[11] = mk(0,0,0,0,0,0,0, 0, 0,0,0, 0,0, 1,9, 0,0,1, 1,1);
        tv[12] = mk(0,0,0,0,0,0,0, 0, 0,0,0, 0,0, 0,7, 0,0,0, 1,1);

        do_reset();
        foreach (tv[i]) begin
            drive(tv[i].rs, tv[i].rt, tv[i].ur, tv[i].ut, tv[i].rw, tv[i].mr, tv[i].wr, tv[i].br);
            e = {tv[i].st, tv[i].st, tv[i].fd, tv[i].fe, tv[i].fa, tv[i].fb, tv[i].rww, tv[i].wrw,
                 tv[i].ve, tv[i].vm, tv[i].vw, 16'(tv[i].sc), 16'(tv[i].fc)};
            chk($sformatf("vec%0d", i), o[1], e);
        end

        // no forwarding: dependent add waits for the producer to leave E, M and W
        do_reset();
        drive(0,0,0,0,0,0,0,0);
        drive(1,2,1,1,1,0,3,0);
        exp_st = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            drive(3,1,1,1,1,0,5,0);
            chk($sformatf("nofwd_stall%0d", i), {sf[0], sd[0], fe[0], fa[0], fb[0]},
                {exp_st[3-i], exp_st[3-i], exp_st[3-i], 4'b0000});
        end
        chk("nofwd_count", 64'(sc[0]), 64'd3);

        // asynchronous reset in the middle of a load-use stall
        do_reset();
        drive(0,0,0,0,0,0,0,0);
        drive(1,0,1,0,1,1,2,0);
        drive(2,2,1,1,1,0,4,0);
        chk("rst_pre_stall", {sf[1], fe[1]}, 2'b11);
        reset = 1'b0;
        #1;
        chk("rst_async_out", {o[1], o[0]}, '0);
        #1 reset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            drive(1, 1, 1, 1, 1, 0, 5'(10 + k), 0);
            chk($sformatf("rst_rel_edge%0d", k), {sf[1], sf[0], vw[1]}, {2'b00, k >= 4});
        end

        // randomized stimulus against the reference model
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 3; k++) ms[f][k] = '0;
            mvd[f] = 1'b0;
            msc[f] = 0;
            mfc[f] = 0;
        end
        for (int n = 0; n < 1500; n++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), ($urandom % 10) == 0);
            chk($sformatf("rnd_fwd%0d", n), o[1], mexp(1));
            chk($sformatf("rnd_nofwd%0d", n), o[0], mexp(0));
            @(posedge clk);
            mstep(0);
            mstep(1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
